// File: rtl/sub_pkg.sv
// Shared definitions for the multicycle subtractor: FSM encoding and
// helpers that size the slice count and slice counter.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple-borrow subtractor slice built from
// full-subtractor cells; also exposes the borrow into its top bit.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_s,
  input  logic [DIGIT-1:0] b_s,
  input  logic             bi,
  output logic [DIGIT-1:0] d_s,
  output logic             bo,
  output logic             b_msb
);

  logic brw;

  always_comb begin
    brw   = bi;
    d_s   = '0;
    b_msb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) b_msb = brw;
      d_s[i] = a_s[i] ^ b_s[i] ^ brw;
      brw    = (~a_s[i] & b_s[i]) | ((~a_s[i] | b_s[i]) & brw);
    end
    bo = brw;
  end

endmodule

// File: rtl/multicycle_subtractor.sv
// Sequential subtractor: diff = a - b - bin, DIGIT bits per clock with the
// borrow carried between slices in a register; valid/ready on both sides.
module multicycle_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = nslice(WIDTH, DIGIT);
  localparam int CW     = cnt_width(NSLICE);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("multicycle_subtractor: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; in_ready is high only in IDLE, out_valid only in DONE.
  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  op_a, op_b, diff_nx;
  logic              brw;
  logic [DIGIT-1:0]  a_s, b_s, d_s;
  logic              s_bo, s_bmsb, last;

  assign a_s  = op_a[int'(cnt) * DIGIT +: DIGIT];
  assign b_s  = op_b[int'(cnt) * DIGIT +: DIGIT];
  assign last = (cnt == CW'(NSLICE - 1));

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_s  (a_s),
    .b_s  (b_s),
    .bi   (brw),
    .d_s  (d_s),
    .bo   (s_bo),
    .b_msb(s_bmsb)
  );

  always_comb begin
    diff_nx = diff;
    diff_nx[int'(cnt) * DIGIT +: DIGIT] = d_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      op_a <= '0;
      op_b <= '0;
      brw  <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a <= a;
            op_b <= b;
            brw  <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          diff <= diff_nx;
          brw  <= s_bo;
          cnt  <= cnt + CW'(1);
          // Final slice holds bit WIDTH-1, so its borrows define the flags.
          if (last) begin
            bout <= s_bo;
            ovf  <= s_bmsb ^ s_bo;
            zero <= (diff_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Directed-vector bench for multicycle_subtractor (16/4 and 8/8 configurations).
module tb_multicycle_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout, ovf, zero;
  logic [15:0] a, b, diff;

  logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8, ovf8, zero8;
  logic [7:0] a8, b8, diff8;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  multicycle_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .ovf(ovf8), .zero(zero8)
  );

  // out_valid must never appear without an accepted operation outstanding.
  logic pending;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 1'b0;
    else if (in_valid && in_ready) pending <= 1'b1;
    else if (out_valid && out_ready) pending <= 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (out_valid && !pending) begin
        n_bad++;
        $display("FAIL spurious_out_valid: out_valid=%b without accept", out_valid);
      end
    end
  end

  // Accept one operation, scramble inputs afterwards, stop at negedge with out_valid.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                        output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({in_ready, out_valid, diff, bout, ovf, zero} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      n_bad++;
      $display("FAIL reset: rdy=%b vld=%b diff=%h bo=%b ov=%b z=%b want 1 0 0000 0 0 0",
               in_ready, out_valid, diff, bout, ovf, zero);
    end
    n_cmp++;
    if ({in_ready8, out_valid8, diff8} !== {1'b1, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset8: rdy=%b vld=%b diff=%h want 1 0 00", in_ready8, out_valid8, diff8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vec(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tbin, input logic [15:0] ed, input logic eb,
                          input logic eo, input logic ez);
    int lat;
    run_op(ta, tb_v, tbin, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d want 4", name, lat);
    end
    n_cmp++;
    if ({diff, bout, ovf, zero} !== {ed, eb, eo, ez}) begin
      n_bad++;
      $display("FAIL %s: diff=%h bo=%b ov=%b z=%b want %h %b %b %b",
               name, diff, bout, ovf, zero, ed, eb, eo, ez);
    end
    release_out();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL %s_return_idle: rdy=%b vld=%b want 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_hold();
    int lat;
    run_op(16'h1234, 16'h0234, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 16'hFFFF ^ 16'(i);
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, diff, bout, ovf, zero} !== {2'b10, 16'h1000, 3'b000}) begin
        n_bad++;
        $display("FAIL hold_%0d: vld=%b rdy=%b diff=%h bo=%b ov=%b z=%b want 1 0 1000 0 0 0",
                 i, out_valid, in_ready, diff, bout, ovf, zero);
      end
    end
    in_valid = 1'b0;
    release_out();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL hold_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, diff, bout, zero} !== {2'b01, 16'h0000, 2'b00}) begin
      n_bad++;
      $display("FAIL mid_run_reset: vld=%b rdy=%b diff=%h bo=%b z=%b want 0 1 0000 0 0",
               out_valid, in_ready, diff, bout, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL discarded_op_%0d: out_valid=%b want 0", i, out_valid);
      end
    end
    test_vec("after_reset", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_width8();
    int lat;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
    lat = 99;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (out_valid8) begin
        lat = n;
        break;
      end
    end
    n_cmp++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL w8_latency: got %0d want 1", lat);
    end
    n_cmp++;
    if ({diff8, bout8, ovf8, zero8} !== {8'hF0, 3'b100}) begin
      n_bad++;
      $display("FAIL w8_result: diff=%h bo=%b ov=%b z=%b want f0 1 0 0", diff8, bout8, ovf8, zero8);
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    n_cmp++;
    if ({in_ready8, out_valid8} !== 2'b10) begin
      n_bad++;
      $display("FAIL w8_idle: rdy=%b vld=%b want 1 0", in_ready8, out_valid8);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra, rb, ed;
    logic        rbin, eb, eo;
    int          sr;
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom_range(0, 1));
      {eb, ed} = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      sr = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
      eo = (sr > 32767) || (sr < -32768);
      test_vec("random", ra, rb, rbin, ed, eb, eo, (ed == 16'h0000));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    test_reset();
    test_vec("t1_basic",    16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    test_vec("t2_wrap",     16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    test_vec("t2_ovf",      16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    test_vec("t3_zero",     16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    test_vec("t3_ovf_bo",   16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    test_vec("bin_only",    16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    test_vec("zero_bo",     16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    test_vec("min_minus_1", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    test_hold();
    test_reset_mid_run();
    test_width8();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
